// File: rtl/arm_enc_pkg.sv
// Shared encodings for the ARM instruction encoder: class/command codes,
// field positions and the pure field-to-word packing function.
package arm_enc_pkg;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_ILL = 2'b11
  } cls_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_EOR = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_ORR = 4'b1100
  } cmd_e;

  localparam int COND_LSB  = 28;
  localparam int CLASS_LSB = 26;
  localparam int I_BIT     = 25;
  localparam int CMD_LSB   = 21;
  localparam int S_BIT     = 20;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;

  // Memory words always use pre-indexed, up, word, no writeback: P U B W.
  localparam logic [3:0] MEM_PUBW = 4'b1100;
  localparam logic [1:0] BR_TAG   = 2'b10;

  // Returns {legal, instr}; instr is don't-care when legal is 0.
  function automatic logic [32:0] pack_instr(
    input logic [1:0]  cls,
    input logic [3:0]  cond,
    input logic [3:0]  cmd,
    input logic        s,
    input logic        imm,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [23:0] operand
  );
    logic [31:0] w;
    logic        legal;
    w = '0;
    legal = 1'b0;
    w[COND_LSB +: 4] = cond;
    case (cls)
      CLS_DP: begin
        w[CLASS_LSB +: 2] = CLS_DP;
        w[I_BIT]          = imm;
        w[CMD_LSB +: 4]   = cmd;
        w[S_BIT]          = s;
        w[RN_LSB +: 4]    = rn;
        w[RD_LSB +: 4]    = rd;
        w[11:0]           = operand[11:0];
        legal = cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_EOR};
      end
      CLS_MEM: begin
        // Immediate offsets are encoded with I clear in the memory class.
        w[CLASS_LSB +: 2] = CLS_MEM;
        w[I_BIT]          = ~imm;
        w[CMD_LSB +: 4]   = MEM_PUBW;
        w[S_BIT]          = s;
        w[RN_LSB +: 4]    = rn;
        w[RD_LSB +: 4]    = rd;
        w[11:0]           = operand[11:0];
        legal = 1'b1;
      end
      CLS_BR: begin
        w[CLASS_LSB +: 2] = CLS_BR;
        w[25:24]          = BR_TAG;
        w[23:0]           = operand;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    return {legal, w};
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry first-in first-out buffer with occupancy count and flush.
module enc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & (count != 2'd2);
  assign dout    = head;
  assign valid   = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // Push and pop together only happens at count 1: the new word becomes head.
        2'b11: head <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs field-level requests into 32-bit words,
// tags them with a sequential address and buffers them in a 2-entry FIFO.
module instr_encoder
  import arm_enc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic              in_imm,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [23:0]       in_operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              wrapped
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and in_ready depends only on FIFO state,
  // clr and reset, never on out_ready.
  logic [1:0]          count;
  logic [32:0]         enc;
  logic                accept;
  logic                push;
  logic                pop;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [31+ADDR_W:0]  head;

  assign enc      = pack_instr(in_class, in_cond, in_cmd, in_s, in_imm, in_rn, in_rd, in_operand);
  assign in_ready = (count != 2'd2) & ~clr & reset;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc[32];
  assign pop      = out_valid & out_ready;

  enc_fifo2 #(.W(32 + ADDR_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clr),
    .push  (push),
    .din   ({addr_cnt, enc[31:0]}),
    .pop   (pop),
    .dout  (head),
    .valid (out_valid),
    .count (count)
  );

  assign out_instr = head[31:0];
  assign out_addr  = head[31+ADDR_W:32];

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      addr_cnt <= '0;
      wrapped  <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      err <= accept & ~enc[32];
      if (push) begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
        if (&addr_cnt) wrapped <= 1'b1;
      end
      if (accept && !enc[32] && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, multi-cycle corner sequences
// and randomized traffic checked every cycle against a behavioural model.
module tb_instr_encoder;

  localparam int AW = 2;
  localparam int W  = 32 + AW;

  logic          clk = 1'b0;
  logic          reset, clr, in_valid, in_ready;
  logic [1:0]    in_class;
  logic [3:0]    in_cond, in_cmd, in_rn, in_rd;
  logic          in_s, in_imm;
  logic [23:0]   in_operand;
  logic          out_valid, out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err, wrapped;
  logic [7:0]    err_cnt;

  typedef struct {
    logic [1:0]  cls;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic        imm;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] opnd;
    logic        legal;
    logic [31:0] instr;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [AW-1:0] got_addr[$];
  int  m_addr = 0;
  int  m_cnt  = 0;
  bit  m_wrap = 0;
  bit  m_err  = 0;
  bit  chk_en = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_cond(in_cond), .in_cmd(in_cmd),
    .in_s(in_s), .in_imm(in_imm), .in_rn(in_rn), .in_rd(in_rd),
    .in_operand(in_operand),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt), .wrapped(wrapped)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_encode(input vec_t v);
    logic [31:0] w;
    bit ok;
    w  = 32'd0;
    ok = 1'b1;
    case (v.cls)
      2'd0: begin
        ok = (v.cmd == 4) || (v.cmd == 2) || (v.cmd == 0) || (v.cmd == 12) || (v.cmd == 1);
        w = 32'(v.cond) * 32'h1000_0000 + 32'(v.imm) * 32'h0200_0000 + 32'(v.cmd) * 32'h0020_0000
          + 32'(v.s) * 32'h0010_0000 + 32'(v.rn) * 32'h0001_0000 + 32'(v.rd) * 32'h0000_1000
          + 32'(v.opnd) % 32'd4096;
      end
      2'd1: begin
        w = 32'(v.cond) * 32'h1000_0000 + 32'h0400_0000 + (v.imm ? 32'd0 : 32'h0200_0000)
          + 32'h0100_0000 + 32'h0080_0000 + 32'(v.s) * 32'h0010_0000
          + 32'(v.rn) * 32'h0001_0000 + 32'(v.rd) * 32'h0000_1000 + 32'(v.opnd) % 32'd4096;
      end
      2'd2: w = 32'(v.cond) * 32'h1000_0000 + 32'h0A00_0000 + 32'(v.opnd);
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- scoreboard / cycle monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      vec_t v;
      logic [32:0] r;
      int sz;
      bit acc;
      chk("in_ready", in_ready, (reset && !clr && exp_q.size() < 2));
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("out_instr", out_instr, exp_q[0][31:0]);
        chk("out_addr", out_addr, exp_q[0][W-1:32]);
      end
      chk("err", err, m_err);
      chk("err_cnt", err_cnt, m_cnt);
      chk("wrapped", wrapped, m_wrap);

      m_err = 1'b0;
      if (!reset || clr) begin
        exp_q.delete();
        m_addr = 0;
        m_wrap = 0;
        m_cnt  = 0;
      end else begin
        sz  = exp_q.size();
        acc = in_valid && (sz < 2);
        if (out_ready && sz > 0) begin
          got_addr.push_back(out_addr);
          void'(exp_q.pop_front());
        end
        if (acc) begin
          v.cls = in_class; v.cond = in_cond; v.cmd = in_cmd; v.s = in_s; v.imm = in_imm;
          v.rn = in_rn; v.rd = in_rd; v.opnd = in_operand; v.legal = 1'b0; v.instr = '0;
          r = ref_encode(v);
          if (r[32]) begin
            exp_q.push_back({AW'(m_addr), r[31:0]});
            if (m_addr == (1 << AW) - 1) m_wrap = 1;
            m_addr = (m_addr + 1) % (1 << AW);
          end else begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input vec_t v);
    bit acc;
    int n;
    in_class = v.cls; in_cond = v.cond; in_cmd = v.cmd; in_s = v.s; in_imm = v.imm;
    in_rn = v.rn; in_rd = v.rd; in_operand = v.opnd;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic vec_t mk(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                              input logic s, input logic imm, input logic [3:0] rn,
                              input logic [3:0] rd, input logic [23:0] opnd,
                              input logic legal, input logic [31:0] instr);
    vec_t v;
    v.cls = cls; v.cond = cond; v.cmd = cmd; v.s = s; v.imm = imm;
    v.rn = rn; v.rd = rd; v.opnd = opnd; v.legal = legal; v.instr = instr;
    return v;
  endfunction

  vec_t tab[10];
  bit   rnd_on;

  initial begin
    int tab_addr;
    int n_ill;
    vec_t a;

    tab[0] = mk(2'd0, 4'hE, 4'b0100, 0, 1, 4'd2, 4'd1, 24'h000005, 1, 32'hE282_1005);
    tab[1] = mk(2'd0, 4'hE, 4'b0010, 1, 0, 4'd3, 4'd3, 24'h000004, 1, 32'hE053_3004);
    tab[2] = mk(2'd1, 4'hE, 4'b0000, 1, 1, 4'd1, 4'd0, 24'h000008, 1, 32'hE591_0008);
    tab[3] = mk(2'd2, 4'h0, 4'b0000, 0, 0, 4'd0, 4'd0, 24'h000003, 1, 32'h0A00_0003);
    tab[4] = mk(2'd0, 4'hE, 4'b1111, 0, 0, 4'd1, 4'd1, 24'h000001, 0, 32'h0);
    tab[5] = mk(2'd3, 4'hE, 4'b0100, 0, 0, 4'd1, 4'd1, 24'h000001, 0, 32'h0);
    tab[6] = mk(2'd0, 4'h1, 4'b1100, 1, 1, 4'd5, 4'd6, 24'h000ABC, 1, 32'h1395_6ABC);
    tab[7] = mk(2'd1, 4'hE, 4'b0000, 0, 0, 4'd13, 4'd2, 24'h123FFF, 1, 32'hE78D_2FFF);
    tab[8] = mk(2'd0, 4'h0, 4'b0001, 0, 0, 4'd15, 4'd15, 24'hFFF000, 1, 32'h002F_F000);
    tab[9] = mk(2'd2, 4'hB, 4'b0000, 0, 0, 4'd0, 4'd0, 24'hFFFFFF, 1, 32'hBAFF_FFFF);

    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_class = '0; in_cond = '0; in_cmd = '0; in_s = 1'b0; in_imm = 1'b0;
    in_rn = '0; in_rd = '0; in_operand = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1;
    idle(1);
    reset = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // Table of single requests, each drained before the next.
    tab_addr = 0;
    n_ill = 0;
    for (int i = 0; i < 10; i++) begin
      send(tab[i]);
      @(negedge clk);
      if (tab[i].legal) begin
        chk($sformatf("tab%0d_valid", i), out_valid, 1);
        chk($sformatf("tab%0d_instr", i), out_instr, tab[i].instr);
        chk($sformatf("tab%0d_addr", i), out_addr, tab_addr);
        tab_addr = (tab_addr + 1) % (1 << AW);
      end else begin
        n_ill++;
        chk($sformatf("tab%0d_err", i), err, 1);
        chk($sformatf("tab%0d_novalid", i), out_valid, 0);
        chk($sformatf("tab%0d_errcnt", i), err_cnt, n_ill);
      end
      @(posedge clk); #1;
    end

    // Backpressure: two fill the FIFO, the third waits until draining starts.
    pulse_clr();
    out_ready = 1'b0;
    got_addr.delete();
    send(tab[0]);
    send(tab[1]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_low0", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_low1", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(tab[2]);
    idle(4);
    chk("bp_pops", got_addr.size(), 3);
    for (int i = 0; i < 3 && i < got_addr.size(); i++)
      chk($sformatf("bp_addr%0d", i), got_addr[i], i);

    // Address wrap with a 2-bit counter, then clr.
    pulse_clr();
    got_addr.delete();
    for (int i = 0; i < 5; i++) begin
      send(tab[9]);
      @(negedge clk);
      if (i == 2) chk("wrap_not_yet", wrapped, 0);
      if (i == 4) chk("wrap_set", wrapped, 1);
      @(posedge clk); #1;
    end
    idle(3);
    chk("wrap_pops", got_addr.size(), 5);
    for (int i = 0; i < 5 && i < got_addr.size(); i++)
      chk($sformatf("wrap_addr%0d", i), got_addr[i], i % 4);
    out_ready = 1'b0;
    send(tab[0]);
    pulse_clr();
    @(negedge clk);
    chk("clr_valid", out_valid, 0);
    chk("clr_wrapped", wrapped, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    got_addr.delete();
    send(tab[6]);
    idle(2);
    chk("clr_pops", got_addr.size(), 1);
    if (got_addr.size() > 0) chk("clr_addr", got_addr[0], 0);

    // Reset mid-stream with two words queued and a nonzero error count.
    out_ready = 1'b0;
    send(tab[5]);
    send(tab[0]);
    send(tab[1]);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    got_addr.delete();
    idle(2);
    send(tab[7]);
    idle(2);
    chk("rst_pops", got_addr.size(), 1);
    if (got_addr.size() > 0) chk("rst_addr", got_addr[0], 0);

    // Randomized traffic with random backpressure and occasional clr.
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2));
          if ($urandom_range(0, 40) == 0) pulse_clr();
          a.cls  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          case ($urandom_range(0, 5))
            0: a.cmd = 4'b0100;
            1: a.cmd = 4'b0010;
            2: a.cmd = 4'b0000;
            3: a.cmd = 4'b1100;
            4: a.cmd = 4'b0001;
            default: a.cmd = 4'($urandom_range(0, 15));
          endcase
          a.cond = 4'($urandom_range(0, 15));
          a.s    = 1'($urandom_range(0, 1));
          a.imm  = 1'($urandom_range(0, 1));
          a.rn   = 4'($urandom_range(0, 15));
          a.rd   = 4'($urandom_range(0, 15));
          a.opnd = 24'($urandom);
          a.legal = 1'b0;
          a.instr = '0;
          send(a);
        end
        rnd_on = 0;
      end
    join
    out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
